counter_sequencer: RTL and testbench

//   Controller that sequences the 8-bit up-counter datapath (clear/enable interface).

---
 rtl/counter_sequencer_if.sv | 30 +++
 rtl/counter_sequencer.sv | 126 ++++++++++++
 tb/tb_counter_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_sequencer_if.sv
// Control/status bundle between a pulse-driven controller and the counter
// sequencer, including the counter's clear/enable/value hookup.
interface counter_sequencer_if #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
);
  logic                  start;
  logic                  stop;
  logic                  mode;
  logic [WIDTH-1:0]      limit;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      cnt_value;
  logic                  cnt_clr;
  logic                  cnt_en;
  logic                  busy;
  logic                  done;
  logic [7:0]            periods;

  // Controller side: issues requests, owns the counter value.
  modport master (
    output start, stop, mode, limit, prescale, cnt_value,
    input  cnt_clr, cnt_en, busy, done, periods
  );

  // Sequencer side.
  modport slave (
    input  start, stop, mode, limit, prescale, cnt_value,
    output cnt_clr, cnt_en, busy, done, periods
  );
endinterface

// File: rtl/counter_sequencer.sv
// Counter sequencer: clears the external up-counter on start, paces its
// increments through a prescaler, detects the terminal value and reports
// completion in one-shot or periodic mode.
module counter_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             reset,   // asynchronous, active-low
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_mode_lat;
  logic [WIDTH-1:0]      r_limit_lat;
  logic [PRESCALE_W-1:0] r_prescale_lat;
  logic [PRESCALE_W-1:0] r_pre;
  logic [7:0]            r_periods;
  logic                  r_cnt_clr;
  logic                  r_done;
  logic                  r_busy;

  logic                  w_pre_wrap;
  logic                  w_at_limit;

  assign w_pre_wrap = (r_pre == r_prescale_lat);
  assign w_at_limit = (bus.cnt_value == r_limit_lat);

  // The enable must look at the live counter value so that it drops in the
  // same cycle the counter reaches the limit; the counter therefore never
  // steps past L, even for L = 2^WIDTH-1.
  assign bus.cnt_en  = (r_state == S_RUN) && w_pre_wrap && !w_at_limit;
  assign bus.cnt_clr = r_cnt_clr;
  assign bus.done    = r_done;
  assign bus.busy    = r_busy;
  assign bus.periods = r_periods;

  // Sequencer FSM: state, prescaler, latched run fields and registered outputs.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values; blocking assignments would create order-dependent
  // simulation and a different netlist than the one simulated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_mode_lat     <= 1'b0;
      r_limit_lat    <= '0;
      r_prescale_lat <= '0;
      r_pre          <= '0;
      r_periods      <= 8'd0;
      r_cnt_clr      <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // A start that coincides with stop is treated as cancelled.
          if (bus.start && !bus.stop) begin
            r_state        <= S_CLEAR;
            r_cnt_clr      <= 1'b1;
            r_busy         <= 1'b1;
            r_mode_lat     <= bus.mode;
            r_limit_lat    <= bus.limit;
            r_prescale_lat <= bus.prescale;
            r_periods      <= 8'd0;
          end
        end

        S_CLEAR: begin
          r_cnt_clr <= 1'b0;
          r_pre     <= '0;
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_RUN;
          end
        end

        S_RUN: begin
          // Abort wins over terminal detect: no done pulse on a stopped run.
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pre   <= '0;
          end else if (w_at_limit) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_pre   <= '0;
          end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + 1'b1;
          end
        end

        S_DONE: begin
          // Completion is unconditional; stop is not looked at here.
          r_done <= 1'b0;
          if (r_periods != 8'hFF) begin
            r_periods <= r_periods + 1'b1;
          end
          if (r_mode_lat) begin
            r_state   <= S_CLEAR;
            r_cnt_clr <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_cnt_clr <= 1'b0;
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer with a behavioural 8-bit counter
// hooked to cnt_clr/cnt_en. Expected completion records are queued when a run
// is launched and popped when the DUT pulses done.
module tb_counter_sequencer;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;
  localparam int BUDGET     = 400;

  typedef struct {
    int limit;
    int prescale;
    int exp_done;   // cycle (after the start edge) in which done is high
    int exp_en;     // number of cnt_en cycles in the run
  } vec_t;

  typedef struct {
    int done_cycle;
    int en_cnt;
    int value;
    int periods;    // periods value the cycle after done
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] cnt_q = 8'd0;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t vecs[6];

  counter_sequencer_if #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) bus ();

  counter_sequencer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Counter datapath being sequenced.
  always @(posedge clk) begin
    if (bus.cnt_clr)     cnt_q <= 8'd0;
    else if (bus.cnt_en) cnt_q <= cnt_q + 8'd1;
  end
  assign bus.cnt_value = cnt_q;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One-cycle start pulse; inputs are scrambled right after the sampling edge.
  task automatic pulse_start(input bit mode, input int limit, input int prescale);
    @(negedge clk);
    bus.mode     = mode;
    bus.limit    = limit[7:0];
    bus.prescale = prescale[3:0];
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.mode     = ~mode;
    bus.limit    = 8'($urandom);
    bus.prescale = 4'($urandom);
  endtask

  // One-shot run from the vector table.
  task automatic run_vec(input vec_t v);
    exp_t  e;
    exp_t  got;
    int    en_cnt   = 0;
    int    clr_cnt  = 0;
    int    both_cnt = 0;
    int    k        = 0;
    bit    seen     = 1'b0;
    string tag;
    tag = $sformatf("L%0d_P%0d", v.limit, v.prescale);
    pulse_start(1'b0, v.limit, v.prescale);
    e.done_cycle = v.exp_done;
    e.en_cnt     = v.exp_en;
    e.value      = v.limit;
    e.periods    = 1;
    exp_q.push_back(e);
    while (!seen && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (bus.cnt_en) en_cnt++;
      if (bus.cnt_clr) clr_cnt++;
      if (bus.cnt_en && bus.cnt_clr) both_cnt++;
      if (bus.done) begin
        seen = 1'b1;
        got  = exp_q.pop_front();
        check({tag, " done_cycle"}, k, got.done_cycle);
        check({tag, " en_cycles"}, en_cnt, got.en_cnt);
        check({tag, " value_at_done"}, int'(bus.cnt_value), got.value);
      end
    end
    check({tag, " done_seen"}, int'(seen), 1);
    exp_q.delete();
    @(negedge clk);
    check({tag, " busy_after"}, int'(bus.busy), 0);
    check({tag, " periods"}, int'(bus.periods), 1);
    check({tag, " value_held"}, int'(bus.cnt_value), v.limit);
    check({tag, " clr_cycles"}, clr_cnt, 1);
    check({tag, " clr_en_overlap"}, both_cnt, 0);
  endtask

  initial begin
    exp_t got;
    int   en_cnt;
    int   run_cnt;
    int   pend;
    int   n_done;
    int   busy_cnt;
    int   spacing_err;
    bit   seen;

    vecs[0] = '{limit: 3,   prescale: 0,  exp_done: 6,   exp_en: 3};
    vecs[1] = '{limit: 0,   prescale: 0,  exp_done: 3,   exp_en: 0};
    vecs[2] = '{limit: 5,   prescale: 1,  exp_done: 13,  exp_en: 5};
    vecs[3] = '{limit: 2,   prescale: 15, exp_done: 35,  exp_en: 2};
    vecs[4] = '{limit: 255, prescale: 0,  exp_done: 258, exp_en: 255};
    vecs[5] = '{limit: 1,   prescale: 3,  exp_done: 7,   exp_en: 1};

    bus.start = 1'b0; bus.stop = 1'b0; bus.mode = 1'b0;
    bus.limit = 8'd0; bus.prescale = 4'd0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset busy",    int'(bus.busy),    0);
    check("reset cnt_clr", int'(bus.cnt_clr), 0);
    check("reset cnt_en",  int'(bus.cnt_en),  0);
    check("reset done",    int'(bus.done),    0);
    check("reset periods", int'(bus.periods), 0);
    reset = 1'b1;

    // One-shot vectors.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // start together with stop in IDLE: nothing happens, periods kept.
    @(negedge clk);
    bus.start = 1'b1; bus.stop = 1'b1; bus.limit = 8'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.busy || bus.cnt_clr) busy_cnt++;
    end
    check("start_stop idle_cycles_busy", busy_cnt, 0);
    check("start_stop periods_kept", int'(bus.periods), 1);

    // start with a new limit during RUN is ignored.
    pulse_start(1'b0, 6, 1);
    seen = 1'b0;
    for (int k = 1; k <= BUDGET && !seen; k++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        check("busy_start done_cycle", k, 15);
        check("busy_start value", int'(bus.cnt_value), 6);
      end
      if (k == 8) begin
        bus.start = 1'b1; bus.limit = 8'd2; bus.mode = 1'b1; bus.prescale = 4'd0;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    check("busy_start done_seen", int'(seen), 1);
    n_done = 0; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
      if (bus.busy) busy_cnt++;
    end
    check("busy_start extra_done", n_done, 0);
    check("busy_start busy_after", busy_cnt, 0);

    // stop in DONE ignored, stop in CLEAR aborts (periodic L=2, P=0).
    pulse_start(1'b1, 2, 0);
    for (int k = 1; k <= 5; k++) @(negedge clk);
    check("stop_done done_c5", int'(bus.done), 1);
    bus.stop = 1'b1;
    @(negedge clk);
    check("stop_done busy_c6", int'(bus.busy), 1);
    check("stop_done clr_c6",  int'(bus.cnt_clr), 1);
    @(negedge clk);
    bus.stop = 1'b0;
    check("stop_clear busy_c7", int'(bus.busy), 0);
    check("stop_clear value_c7", int'(bus.cnt_value), 0);
    check("stop_clear periods", int'(bus.periods), 1);

    // Periodic L=4, P=2: done every 15 cycles, then stop in RUN.
    pulse_start(1'b1, 4, 2);
    for (int i = 1; i <= 3; i++)
      exp_q.push_back('{done_cycle: 15 * i, en_cnt: 4, value: 4, periods: i});
    en_cnt = 0; run_cnt = 0; pend = -1;
    for (int k = 1; k <= 53; k++) begin
      @(negedge clk);
      if (pend >= 0) begin
        check("periodic periods", int'(bus.periods), pend);
        pend = -1;
      end
      if (bus.cnt_en) en_cnt++;
      if (bus.busy && !bus.cnt_clr && !bus.done) run_cnt++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("periodic unexpected_done_cycle", k, -1);
        end else begin
          got = exp_q.pop_front();
          check("periodic done_cycle", k, got.done_cycle);
          check("periodic en_cycles", en_cnt, got.en_cnt);
          check("periodic run_cycles", run_cnt, 13);
          check("periodic value", int'(bus.cnt_value), got.value);
          pend = got.periods;
        end
        en_cnt = 0; run_cnt = 0;
      end
    end
    check("periodic missing_done", exp_q.size(), 0);
    exp_q.delete();
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
    @(negedge clk);
    check("stop_run busy", int'(bus.busy), 0);
    check("stop_run value", int'(bus.cnt_value), 2);
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("stop_run extra_done", n_done, 0);
    check("stop_run value_held", int'(bus.cnt_value), 2);
    check("stop_run periods", int'(bus.periods), 3);

    // Saturation: periodic L=1, P=0 -> done every 4 cycles, 300 periods.
    pulse_start(1'b1, 1, 0);
    n_done = 0; spacing_err = 0;
    for (int k = 1; k <= 1200; k++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (k != 4 * n_done) spacing_err++;
      end
      if (k == 1017) check("sat periods_254", int'(bus.periods), 254);
      if (k == 1021) check("sat periods_255", int'(bus.periods), 255);
    end
    check("sat done_count", n_done, 300);
    check("sat spacing_errors", spacing_err, 0);
    @(negedge clk);
    check("sat periods_held", int'(bus.periods), 255);
    check("sat busy_cycle", int'(bus.busy), 1);
    #2 reset = 1'b0;
    #1;
    check("sat_reset periods", int'(bus.periods), 0);
    check("sat_reset busy", int'(bus.busy), 0);
    @(negedge clk);
    reset = 1'b1;

    // Reset pulse mid-run, L=200, P=0.
    pulse_start(1'b0, 200, 0);
    repeat (50) @(negedge clk);
    check("midrun busy_before",   int'(bus.busy),   1);
    check("midrun cnt_en_before", int'(bus.cnt_en), 1);
    #2 reset = 1'b0;
    #1;
    check("midrun busy",    int'(bus.busy),    0);
    check("midrun cnt_en",  int'(bus.cnt_en),  0);
    check("midrun cnt_clr", int'(bus.cnt_clr), 0);
    check("midrun done",    int'(bus.done),    0);
    @(negedge clk);
    reset = 1'b1;
    busy_cnt = 0; n_done = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.busy || bus.cnt_en || bus.cnt_clr) busy_cnt++;
      if (bus.done) n_done++;
    end
    check("midrun idle_after", busy_cnt, 0);
    check("midrun no_done", n_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
